// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall, flush, drain and halt control with IF/ID register
module pipe_stall_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_req,
    input  logic        flush,
    input  logic        halt_req,
    input  logic        resume,
    input  logic        mem_busy,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_in,
    output logic        pc_enable,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic        ifid_valid,
    output logic        bubble,
    output logic        pipe_freeze,
    output logic        halted,
    output logic [7:0]  stall_cycles
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] drain_cnt;
    logic [1:0] drain_next;
    logic       ifid_load;
    logic       ifid_nop;
    logic       count_en;

    // State and drain counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= 2'd0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
        end
    end

    // Next-state and control decode; in RUN a flush outranks a memory freeze
    always_comb begin
        state_next  = state;
        drain_next  = drain_cnt;
        pc_enable   = 1'b0;
        bubble      = 1'b0;
        pipe_freeze = 1'b0;
        halted      = (state == HALT);
        ifid_load   = 1'b0;
        ifid_nop    = 1'b0;
        case (state)
            RUN: begin
                if (flush) begin
                    pc_enable = 1'b1;
                    bubble    = 1'b1;
                    ifid_nop  = 1'b1;
                end else if (mem_busy) begin
                    pipe_freeze = 1'b1;
                end else if (halt_req) begin
                    bubble     = 1'b1;
                    ifid_nop   = 1'b1;
                    state_next = DRAIN;
                    drain_next = 2'd2;
                end else if (stall_req) begin
                    bubble = 1'b1;
                end else begin
                    pc_enable = 1'b1;
                    ifid_load = 1'b1;
                end
            end
            DRAIN: begin
                if (mem_busy) begin
                    pipe_freeze = 1'b1;
                end else begin
                    bubble = 1'b1;
                    if (drain_cnt <= 2'd1) begin
                        drain_next = 2'd0;
                        state_next = HALT;
                    end else begin
                        drain_next = drain_cnt - 2'd1;
                    end
                end
            end
            HALT: begin
                if (mem_busy) begin
                    pipe_freeze = 1'b1;
                end else begin
                    bubble = 1'b1;
                    if (resume) begin
                        state_next = RUN;
                    end
                end
            end
            default: begin
                state_next = RUN;
                drain_next = 2'd0;
            end
        endcase
    end

    // Every PC-hold cycle outside HALT counts toward the stall statistic
    always_comb begin
        count_en = !pc_enable && (state != HALT);
    end

    // IF/ID register: load on normal fetch, clear to an invalid NOP on flush or halt
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_instr <= 16'h0000;
            ifid_pc    <= 16'h0000;
            ifid_valid <= 1'b0;
        end else if (ifid_nop) begin
            ifid_instr <= 16'h0000;
            ifid_pc    <= 16'h0000;
            ifid_valid <= 1'b0;
        end else if (ifid_load) begin
            ifid_instr <= instr_in;
            ifid_pc    <= pc_in;
            ifid_valid <= 1'b1;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 8'h00;
        end else if (count_en && (stall_cycles != 8'hFF)) begin
            stall_cycles <= stall_cycles + 8'h01;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed self-checking bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_req;
    logic        flush;
    logic        halt_req;
    logic        resume;
    logic        mem_busy;
    logic [15:0] instr_in;
    logic [15:0] pc_in;
    logic        pc_enable;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic        ifid_valid;
    logic        bubble;
    logic        pipe_freeze;
    logic        halted;
    logic [7:0]  stall_cycles;

    int total;
    int bad;

    pipe_stall_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stall_req    (stall_req),
        .flush        (flush),
        .halt_req     (halt_req),
        .resume       (resume),
        .mem_busy     (mem_busy),
        .instr_in     (instr_in),
        .pc_in        (pc_in),
        .pc_enable    (pc_enable),
        .ifid_instr   (ifid_instr),
        .ifid_pc      (ifid_pc),
        .ifid_valid   (ifid_valid),
        .bubble       (bubble),
        .pipe_freeze  (pipe_freeze),
        .halted       (halted),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_instr"}, ifid_instr, 16'h0000);
        chk({tag, "_pc"}, ifid_pc, 16'h0000);
        chk({tag, "_valid"}, {15'd0, ifid_valid}, 16'd0);
        chk({tag, "_stall"}, {8'd0, stall_cycles}, 16'd0);
        chk({tag, "_pc_en"}, {15'd0, pc_enable}, 16'd1);
        chk({tag, "_bubble"}, {15'd0, bubble}, 16'd0);
        chk({tag, "_freeze"}, {15'd0, pipe_freeze}, 16'd0);
        chk({tag, "_halted"}, {15'd0, halted}, 16'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        stall_req = 1'b0;
        flush     = 1'b0;
        halt_req  = 1'b0;
        resume    = 1'b0;
        mem_busy  = 1'b0;
        instr_in  = 16'h0000;
        pc_in     = 16'h0000;

        do_reset();
        check_reset_values("rst0");

        // Normal fetch
        instr_in = 16'h1234;
        pc_in    = 16'h0010;
        tick();
        chk("fetch_instr", ifid_instr, 16'h1234);
        chk("fetch_pc", ifid_pc, 16'h0010);
        chk("fetch_valid", {15'd0, ifid_valid}, 16'd1);

        // Load-use stall holding IF/ID = 2345
        instr_in = 16'h2345;
        pc_in    = 16'h0012;
        tick();
        instr_in  = 16'h3456;
        pc_in     = 16'h0014;
        stall_req = 1'b1;
        #1;
        chk("stall_pc_en", {15'd0, pc_enable}, 16'd0);
        chk("stall_bubble", {15'd0, bubble}, 16'd1);
        tick();
        stall_req = 1'b0;
        #1;
        chk("stall_hold_instr", ifid_instr, 16'h2345);
        chk("stall_hold_pc", ifid_pc, 16'h0012);
        chk("stall_count1", {8'd0, stall_cycles}, 16'd1);

        // Flush wins over a simultaneous stall
        flush     = 1'b1;
        stall_req = 1'b1;
        #1;
        chk("flush_pc_en", {15'd0, pc_enable}, 16'd1);
        chk("flush_bubble", {15'd0, bubble}, 16'd1);
        tick();
        flush     = 1'b0;
        stall_req = 1'b0;
        #1;
        chk("flush_instr", ifid_instr, 16'h0000);
        chk("flush_valid", {15'd0, ifid_valid}, 16'd0);
        chk("flush_count", {8'd0, stall_cycles}, 16'd1);

        // Refill then freeze for one cycle in RUN
        tick();
        chk("refill_instr", ifid_instr, 16'h3456);
        instr_in = 16'h4567;
        pc_in    = 16'h0016;
        mem_busy = 1'b1;
        #1;
        chk("run_freeze", {15'd0, pipe_freeze}, 16'd1);
        chk("run_freeze_pc_en", {15'd0, pc_enable}, 16'd0);
        chk("run_freeze_bubble", {15'd0, bubble}, 16'd0);
        tick();
        mem_busy = 1'b0;
        #1;
        chk("run_freeze_hold", ifid_instr, 16'h3456);

        // Halt: two drain cycles, then HALT, then resume
        do_reset();
        halt_req = 1'b1;
        #1;
        chk("halt_pc_en", {15'd0, pc_enable}, 16'd0);
        chk("halt_bubble", {15'd0, bubble}, 16'd1);
        tick();
        halt_req = 1'b0;
        resume   = 1'b1;
        #1;
        chk("drain1_halted", {15'd0, halted}, 16'd0);
        chk("drain1_bubble", {15'd0, bubble}, 16'd1);
        chk("drain1_valid", {15'd0, ifid_valid}, 16'd0);
        tick();
        resume = 1'b0;
        #1;
        chk("drain2_halted", {15'd0, halted}, 16'd0);
        chk("drain2_pc_en", {15'd0, pc_enable}, 16'd0);
        tick();
        chk("halt_halted", {15'd0, halted}, 16'd1);
        chk("halt_count", {8'd0, stall_cycles}, 16'd3);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        #1;
        chk("halt_still", {15'd0, halted}, 16'd1);
        chk("halt_no_count", {8'd0, stall_cycles}, 16'd3);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        #1;
        chk("resume_halted", {15'd0, halted}, 16'd0);
        chk("resume_pc_en", {15'd0, pc_enable}, 16'd1);
        chk("resume_count", {8'd0, stall_cycles}, 16'd3);

        // Memory wait during DRAIN holds the drain count
        do_reset();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        mem_busy = 1'b1;
        #1;
        chk("drain_freeze", {15'd0, pipe_freeze}, 16'd1);
        chk("drain_freeze_bubble", {15'd0, bubble}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drain_frozen_halted", {15'd0, halted}, 16'd0);
        end
        mem_busy = 1'b0;
        #1;
        chk("drain_resume_freeze", {15'd0, pipe_freeze}, 16'd0);
        tick();
        chk("drain_after1_halted", {15'd0, halted}, 16'd0);
        chk("drain_after1_valid", {15'd0, ifid_valid}, 16'd0);
        tick();
        chk("drain_after2_halted", {15'd0, halted}, 16'd1);

        // Saturation
        do_reset();
        stall_req = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        chk("sat_ff", {8'd0, stall_cycles}, 16'h00FF);
        tick();
        chk("sat_hold", {8'd0, stall_cycles}, 16'h00FF);
        stall_req = 1'b0;
        instr_in  = 16'h5678;
        pc_in     = 16'h0020;
        tick();
        chk("sat_load", ifid_instr, 16'h5678);

        // Reset from RUN with loaded IF/ID
        do_reset();
        check_reset_values("rst_run");

        // Reset mid-DRAIN overrides other inputs
        halt_req = 1'b1;
        tick();
        rst      = 1'b1;
        resume   = 1'b1;
        mem_busy = 1'b1;
        tick();
        rst      = 1'b0;
        resume   = 1'b0;
        mem_busy = 1'b0;
        halt_req = 1'b0;
        #1;
        check_reset_values("rst_drain");

        // Reset from HALT
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        tick();
        chk("pre_rst_halted", {15'd0, halted}, 16'd1);
        do_reset();
        check_reset_values("rst_halt");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL provide: stall_req  input  1  load-use stall request from the hazard detector, combinational, same cycle.
REQ-004 SHALL provide: flush  input  1  branch/jump taken in EX; discard IF/ID contents.
REQ-005 SHALL provide: halt_req  input  1  halt instruction decoded in ID.
REQ-006 SHALL provide: resume  input  1  external restart from HALT.
REQ-007 SHALL provide: mem_busy  input  1  data memory not ready; freeze the whole pipeline.
REQ-008 SHALL provide: instr_in  input  16  fetched instruction; pc_in  input  16  PC of the fetched instruction.
REQ-009 SHALL provide: pc_enable  output  1  PC register load enable.
REQ-010 SHALL provide: ifid_instr  output  16  registered IF/ID instruction; ifid_pc  output  16  registered IF/ID PC; ifid_valid  output  1.
REQ-011 SHALL provide: bubble  output  1  force the ID/EX register to load NOP (16'h0000).
REQ-012 SHALL provide: pipe_freeze  output  1  hold all downstream pipeline registers.
REQ-013 SHALL provide: halted  output  1; stall_cycles  output  8  saturating stall counter.
REQ-014 SHALL use one clock, clk; reset rst is synchronous and active-high.

Function
REQ-015 SHALL implement FSM states RUN, DRAIN, HALT; reset state RUN.
REQ-016 SHALL apply per-cycle priority in RUN: flush > mem_busy > halt_req > stall_req > normal.
REQ-017 RUN normal: pc_enable=1, bubble=0, pipe_freeze=0; at the edge, IF/ID loads instr_in/pc_in with ifid_valid=1.
REQ-018 RUN stall_req: pc_enable=0 and bubble=1 combinationally in the same cycle; IF/ID holds its contents; exactly one bubble is injected per asserted cycle.
REQ-019 RUN flush: pc_enable=1, bubble=1; at the edge, IF/ID loads 16'h0000 with ifid_valid=0; a stall_req in the same cycle is ignored.
REQ-020 mem_busy (any state): pipe_freeze=1, pc_enable=0, bubble=0; IF/ID, the FSM state and the DRAIN count all hold.
REQ-021 RUN halt_req: pc_enable=0, bubble=1; IF/ID loads NOP with ifid_valid=0; go to DRAIN with a 2-bit drain count of 2.
REQ-022 DRAIN: pc_enable=0, bubble=1; decrement the count each non-frozen cycle; enter HALT after the count reaches 0 (two drain cycles).
REQ-023 HALT: halted=1, pc_enable=0, bubble=1; IF/ID holds NOP/invalid; resume=1 moves to RUN at the edge, with pc_enable=1 in the first RUN cycle.
REQ-024 SHALL ignore resume in RUN and DRAIN, and ignore halt_req outside RUN.
REQ-025 stall_cycles SHALL increment by 1 each cycle pc_enable=0 in RUN or DRAIN, saturate at 8'hFF, and never wrap; HALT cycles are not counted.
REQ-026 SHALL make pc_enable, bubble, pipe_freeze and halted combinational from state and inputs only, with no combinational path from instr_in.

Reset
REQ-027 While rst=1 at an edge: state=RUN, ifid_instr=16'h0000, ifid_pc=16'h0000, ifid_valid=0, stall_cycles=0, drain count=0.
REQ-028 Reset outputs after that edge: pc_enable=1, bubble=0, pipe_freeze=0, halted=0, given no other inputs asserted.
REQ-029 Reset asserted mid-DRAIN or in HALT SHALL return to RUN in one edge, overriding all other inputs.

Verification
REQ-030 Normal fetch: instr_in=16'h1234, pc_in=16'h0010, no requests -> next cycle ifid_instr=16'h1234, ifid_pc=16'h0010, ifid_valid=1.
REQ-031 Load-use: stall_req=1 for one cycle with IF/ID=16'h2345 -> same cycle pc_enable=0 and bubble=1; IF/ID stays 16'h2345; stall_cycles=1.
REQ-032 Flush and stall together: flush=1 and stall_req=1 -> pc_enable=1, bubble=1; next cycle ifid_instr=16'h0000, ifid_valid=0; stall_cycles unchanged.
REQ-033 Halt: halt_req=1 -> two DRAIN cycles, then halted=1; resume=1 -> next cycle halted=0, pc_enable=1; stall_cycles=3.
REQ-034 Memory wait: mem_busy=1 for 3 cycles during DRAIN -> drain count and IF/ID hold; HALT is reached 2 non-frozen cycles after mem_busy drops.
REQ-035 Saturation and reset: stall_req held 300 cycles -> stall_cycles=8'hFF; rst=1 for one edge -> all REQ-027 values.
